mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
CPU-side initiator for the byte-addressable data memory with stack. It accepts one load, store, PUSH or POP request at a time from the execute stage and owns the architectural stack pointer. It drives the memory's mem_read/mem_write/address/write-data bus and captures the registered read data. It returns load and POP results to writeback with the destination register tag.

Parameters:
STACK_TOP, 4096, reset value of sp (byte address one past the highest stack word)
STACK_LIMIT, 3072, lowest legal sp value after a PUSH
OP_LW, 6'b001100, load-word opcode
OP_SW, 6'b001101, store-word opcode
OP_PUSH, 6'b001111, PUSH opcode
OP_POP, 6'b010000, POP opcode

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  execute stage presents a request
req_ready  out  1  controller can accept a request this cycle
req_opcode  in  6  operation code
req_base  in  32  base register value (LW/SW)
req_offset  in  16  signed byte offset (LW/SW)
req_wdata  in  32  store/PUSH data
req_rd  in  5  destination register (LW/POP)
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  32  byte address, always word-aligned when a strobe is high
mem_wdata  out  32  write data
mem_rdata  in  32  memory read data, valid the cycle after mem_read
wb_valid  out  1  one-cycle pulse: wb_data/wb_rd valid
wb_rd  out  5  destination register
wb_data  out  32  loaded/popped word
sp  out  32  current stack pointer
err  out  1  one-cycle pulse: request rejected
err_code  out  2  01 misaligned, 10 stack overflow/underflow, 11 illegal opcode; held until next err

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; mem_read=mem_write=0; mem_addr=mem_wdata=0; wb_valid=0, wb_rd=0, wb_data=0; sp=STACK_TOP; err=0, err_code=0. A reset asserted mid-operation drops strobes immediately and abandons the request with no writeback and no sp change.
- All outputs are registered. sp changes only as listed below.
- States: IDLE, WRITE, READ, CAPTURE.
- IDLE: req_ready=1. Handshake occurs when req_valid and req_ready are both 1 at a rising edge. The request is latched, and req_ready=0 from the next cycle until the controller returns to IDLE.
- Address generation: for LW/SW, addr = req_base + sign_extend(req_offset), mod 2^32. PUSH uses addr = sp-4. POP uses addr = sp.
- Error checks, made on the accept edge and mutually exclusive in this priority order:
  - Illegal opcode: code 11.
  - LW/SW with addr[1:0]≠0: code 01.
  - PUSH with sp-4 < STACK_LIMIT: code 10.
  - POP with sp ≥ STACK_TOP: code 10.
  - On any error: err pulses high for the cycle after accept, with no memory strobe, no wb and no sp change. State stays IDLE, so the controller can accept again the next cycle.
- SW/PUSH: next state WRITE. In WRITE, mem_write=1 for exactly one cycle with mem_addr/mem_wdata valid. At the end of WRITE, PUSH sets sp ← sp-4. Return to IDLE. An accept at edge N drives mem_write during cycle N+1, and req_ready=1 again in cycle N+2.
- LW/POP: next state READ. In READ, mem_read=1 for one cycle. Then CAPTURE, where mem_read=0 and mem_rdata is sampled at the end of the cycle. At that same edge, wb_data ← mem_rdata, wb_rd ← latched rd, wb_valid=1 for one cycle, POP sets sp ← sp+4, and the state returns to IDLE.
  - Load-to-writeback latency: accept at edge N gives wb_valid in cycle N+3.
- mem_read and mem_write are never high in the same cycle.
- req_* inputs are ignored while req_ready=0.
- wb_valid and err are never high together.
- sp wraps nowhere: the limit checks guarantee STACK_LIMIT ≤ sp ≤ STACK_TOP.

Test Plan:
- Reset, then PUSH 0xDEADBEEF → mem_write one cycle at addr 4092 with data 0xDEADBEEF; afterwards sp=4092.
- POP with rd=7 after the PUSH → mem_read at 4092; three cycles after accept, wb_valid with wb_rd=7 and wb_data=0xDEADBEEF; sp=4096.
- SW base=0x100, offset=-4, data 0x12345678 → mem_write addr 0xFC. LW with the same operands, memory returning 0x12345678 → wb_data=0x12345678.
- LW base=0x101, offset=0 → err=1, err_code=01, no strobe. POP at sp=4096 → err_code=10, sp unchanged. Opcode 6'b111111 → err_code=11.
- 256 PUSHes with STACK_LIMIT=3072 all succeed (sp=3072). The 257th gives err_code=10, no write, sp=3072.
- rst_n pulled low during READ of a POP → mem_read drops immediately, no wb_valid, sp=4096, req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Request, memory-bus and writeback signals between the execute stage,
// the load/store/stack controller and the data memory.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_opcode;
    logic [31:0] req_base;
    logic [15:0] req_offset;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] sp;
    logic        err;
    logic [1:0]  err_code;

    // Controller side
    modport slave (
        input  req_valid, req_opcode, req_base, req_offset, req_wdata, req_rd, mem_rdata,
        output req_ready, mem_read, mem_write, mem_addr, mem_wdata,
               wb_valid, wb_rd, wb_data, sp, err, err_code
    );

    // Execute stage / memory side
    modport master (
        output req_valid, req_opcode, req_base, req_offset, req_wdata, req_rd, mem_rdata,
        input  req_ready, mem_read, mem_write, mem_addr, mem_wdata,
               wb_valid, wb_rd, wb_data, sp, err, err_code
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store/PUSH/POP initiator that owns the stack
// pointer and returns load/POP data to writeback with the register tag.
module mem_access_ctrl #(
    parameter logic [31:0] STACK_TOP   = 32'd4096,
    parameter logic [31:0] STACK_LIMIT = 32'd3072,
    parameter logic [5:0]  OP_LW       = 6'b001100,
    parameter logic [5:0]  OP_SW       = 6'b001101,
    parameter logic [5:0]  OP_PUSH     = 6'b001111,
    parameter logic [5:0]  OP_POP      = 6'b010000
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} state_t;

    state_t      state_q;
    logic        req_ready_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    logic [31:0] sp_q;
    logic        err_q;
    logic [1:0]  err_code_q;
    logic [4:0]  rd_q;
    logic        is_stack_q;

    logic        is_lw_d, is_sw_d, is_push_d, is_pop_d;
    logic [31:0] eff_addr_d;
    logic [31:0] push_addr_d;
    logic [31:0] req_addr_d;
    logic [1:0]  chk_code_d;

    always_comb begin
        is_lw_d     = (bus.req_opcode == OP_LW);
        is_sw_d     = (bus.req_opcode == OP_SW);
        is_push_d   = (bus.req_opcode == OP_PUSH);
        is_pop_d    = (bus.req_opcode == OP_POP);
        eff_addr_d  = bus.req_base + {{16{bus.req_offset[15]}}, bus.req_offset};
        // sp never drops below STACK_LIMIT, so sp-4 cannot wrap
        push_addr_d = sp_q - 32'd4;
        req_addr_d  = eff_addr_d;
        if (is_push_d)
            req_addr_d = push_addr_d;
        else if (is_pop_d)
            req_addr_d = sp_q;

        chk_code_d = 2'b00;
        if (!(is_lw_d || is_sw_d || is_push_d || is_pop_d))
            chk_code_d = 2'b11;
        else if ((is_lw_d || is_sw_d) && (eff_addr_d[1:0] != 2'b00))
            chk_code_d = 2'b01;
        else if (is_push_d && (push_addr_d < STACK_LIMIT))
            chk_code_d = 2'b10;
        else if (is_pop_d && (sp_q >= STACK_TOP))
            chk_code_d = 2'b10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            sp_q        <= STACK_TOP;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            rd_q        <= '0;
            is_stack_q  <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (chk_code_d != 2'b00) begin
                            // Rejected: stay in IDLE so the next cycle can accept
                            err_q      <= 1'b1;
                            err_code_q <= chk_code_d;
                        end else begin
                            mem_addr_q  <= req_addr_d;
                            rd_q        <= bus.req_rd;
                            is_stack_q  <= is_push_d || is_pop_d;
                            req_ready_q <= 1'b0;
                            if (is_sw_d || is_push_d) begin
                                mem_wdata_q <= bus.req_wdata;
                                mem_write_q <= 1'b1;
                                state_q     <= WRITE;
                            end else begin
                                mem_read_q <= 1'b1;
                                state_q    <= READ;
                            end
                        end
                    end
                end
                WRITE: begin
                    mem_write_q <= 1'b0;
                    if (is_stack_q)
                        sp_q <= sp_q - 32'd4;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                READ: begin
                    mem_read_q <= 1'b0;
                    state_q    <= CAPTURE;
                end
                CAPTURE: begin
                    wb_valid_q <= 1'b1;
                    wb_data_q  <= bus.mem_rdata;
                    wb_rd_q    <= rd_q;
                    if (is_stack_q)
                        sp_q <= sp_q + 32'd4;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.sp        = sp_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
endmodule
